// File: rtl/bcd_rng_gen.sv
// bcd_rng_gen: BCD random-number source built on a free-running Galois LFSR.
// A fetch request produces NUM_DIGITS BCD digits. Digits are collected one per
// accepted nibble into per-digit shadow registers. All of them are published
// to the output together in one cycle, and a one-cycle valid pulse marks that
// cycle. REJECT selects the nibble-to-digit mapping:
//   REJECT=0 : digit = (n*10)>>4, every nibble is accepted, fixed latency.
//   REJECT=1 : nibbles above 9 are discarded, so latency depends on the data.

// One digit lane: the shadow register is filled while generation runs, and the
// visible digit register takes the shadow value only on commit.
module bcd_rng_lane (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_wr,
    input  logic [3:0] i_din,
    input  logic       i_commit,
    output logic [3:0] o_digit
);
    logic [3:0] r_shadow;
    logic [3:0] r_digit;

    // Capture the accepted digit for this lane while generation is in progress.
    always_ff @(posedge clk) begin
        if (!rst)      r_shadow <= 4'd0;
        else if (i_wr) r_shadow <= i_din;
    end

    // Publish the shadow value only on commit, so the output never shows a
    // partially generated number.
    always_ff @(posedge clk) begin
        if (!rst)          r_digit <= 4'd0;
        else if (i_commit) r_digit <= r_shadow;
    end

    assign o_digit = r_digit;
endmodule

module bcd_rng_gen #(
    parameter int                NUM_DIGITS = 4,
    parameter int                LFSR_W     = 16,
    parameter logic [LFSR_W-1:0] TAPS       = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED       = 16'hACE1,
    parameter bit                REJECT     = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    seed_load,
    input  logic [LFSR_W-1:0]       seed_in,
    input  logic                    fetch_req,
    output logic                    busy,
    output logic                    num_valid,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [LFSR_W-1:0]       lfsr_q
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GEN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state, w_state_nxt;
    logic [IDX_W-1:0]      r_idx, w_idx_nxt;
    logic [LFSR_W-1:0]     r_lfsr, w_lfsr_adv, w_lfsr_nxt, w_seed;
    logic                  r_num_valid;
    logic [3:0]            w_nib, w_digit;
    logic [7:0]            w_prod;
    logic                  w_accept, w_take, w_last, w_commit, w_busy;
    logic [NUM_DIGITS-1:0] w_wr;

    // ---------------- LFSR ----------------
    // Right-shifting Galois form. The output bit folds back through the tap mask.
    assign w_lfsr_adv = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
    // A zero seed would lock the LFSR up, so SEED replaces it.
    assign w_seed     = (seed_in == '0) ? SEED : seed_in;
    assign w_lfsr_nxt = seed_load ? w_seed : w_lfsr_adv;

    // The LFSR runs every cycle, whatever the FSM state. A seed load takes
    // priority over the advance.
    always_ff @(posedge clk) begin
        if (!rst) r_lfsr <= SEED;
        else      r_lfsr <= w_lfsr_nxt;
    end

    // ---------------- nibble mapping ----------------
    assign w_nib  = r_lfsr[3:0];
    // Scaling keeps the top 4 bits of n*10. The largest value, 150>>4, is 9,
    // so every nibble maps to a valid BCD digit.
    assign w_prod = {4'd0, w_nib} * 8'd10;

    // Pick the digit value and decide whether this nibble is accepted.
    generate
        if (REJECT) begin : g_reject
            assign w_digit  = w_nib;
            assign w_accept = (w_nib <= 4'd9);
        end else begin : g_scale
            assign w_digit  = w_prod[7:4];
            assign w_accept = 1'b1;
        end
    endgenerate

    assign w_take = (r_state == S_GEN) && w_accept;
    assign w_last = (r_idx == IDX_W'(NUM_DIGITS - 1));

    // ---------------- FSM ----------------
    // State and digit-index registers. A reset in the middle of a fetch drops
    // that fetch, and no valid pulse is issued for it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state logic and decoded controls. fetch_req is sampled only in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_busy      = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (fetch_req) begin
                    w_state_nxt = S_GEN;
                    w_idx_nxt   = '0;
                end
            end
            S_GEN: begin
                w_busy = 1'b1;
                if (w_accept) begin
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            S_DONE: begin
                w_commit    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // The valid pulse is registered so that it lines up with the digit
    // registers taking the committed value.
    always_ff @(posedge clk) begin
        if (!rst) r_num_valid <= 1'b0;
        else      r_num_valid <= w_commit;
    end

    // ---------------- digit lanes ----------------
    genvar k;
    generate
        for (k = 0; k < NUM_DIGITS; k++) begin : g_lane
            assign w_wr[k] = w_take && (r_idx == IDX_W'(k));
            bcd_rng_lane u_lane (
                .clk      (clk),
                .rst      (rst),
                .i_wr     (w_wr[k]),
                .i_din    (w_digit),
                .i_commit (w_commit),
                .o_digit  (digits[4*k +: 4])
            );
        end
    endgenerate

    assign busy      = w_busy;
    assign num_valid = r_num_valid;
    assign lfsr_q    = r_lfsr;
endmodule

// File: tb/tb_bcd_rng_gen.sv
// Directed bench for bcd_rng_gen. The bench drives one set of inputs into two
// instances, a scaled-mapping one (u_dut0) and a rejection-sampled one (u_dut1).
module tb_bcd_rng_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        seed_load = 1'b0;
    logic        fetch_req = 1'b0;
    logic [15:0] seed_in = 16'h0000;

    logic        busy0, nv0, busy1, nv1;
    logic [15:0] digits0, digits1, lfsr0, lfsr1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bcd_rng_gen #(.REJECT(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in),
        .fetch_req(fetch_req), .busy(busy0), .num_valid(nv0),
        .digits(digits0), .lfsr_q(lfsr0)
    );

    bcd_rng_gen #(.REJECT(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in),
        .fetch_req(fetch_req), .busy(busy1), .num_valid(nv1),
        .digits(digits1), .lfsr_q(lfsr1)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0; seed_load = 1'b0; fetch_req = 1'b0;
        repeat (n) step();
        rst = 1'b1;
    endtask

    // This task loads a seed and raises a fetch on the same edge. It then
    // watches both instances for 40 cycles. The expected values are the busy
    // cycle count and the committed digits for each instance. num_valid is
    // expected two samples after busy ends.
    task automatic fetch_check(input string tag, input logic [15:0] seed,
                               input int eb0, input logic [15:0] ed0,
                               input int eb1, input logic [15:0] ed1);
        int b0 = 0, b1 = 0, t0 = 0, t1 = 0, p0 = 0, p1 = 0;
        logic [15:0] d0 = '0, d1 = '0;
        seed_in = seed; seed_load = 1'b1; fetch_req = 1'b1;
        step();
        seed_load = 1'b0; fetch_req = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (busy0) b0++;
            if (busy1) b1++;
            if (nv0) begin p0++; if (t0 == 0) begin t0 = c; d0 = digits0; end end
            if (nv1) begin p1++; if (t1 == 0) begin t1 = c; d1 = digits1; end end
            if (c < 40) step();
        end
        check({tag, ".busy0"},   b0, eb0);
        check({tag, ".lat0"},    t0, eb0 + 2);
        check({tag, ".digits0"}, d0, ed0);
        check({tag, ".pulses0"}, p0, 1);
        check({tag, ".hold0"},   digits0, ed0);
        check({tag, ".busy1"},   b1, eb1);
        check({tag, ".lat1"},    t1, eb1 + 2);
        check({tag, ".digits1"}, d1, ed1);
        check({tag, ".pulses1"}, p1, 1);
        check({tag, ".hold1"},   digits1, ed1);
    endtask

    initial begin
        int np, last, bad, first, z, ret, n1, cyc;
        int hist[10];

        // Reset state
        do_reset(3);
        check("rst.lfsr0", lfsr0, 16'hACE1);
        check("rst.lfsr1", lfsr1, 16'hACE1);
        check("rst.digits0", digits0, 16'h0000);
        check("rst.digits1", digits1, 16'h0000);
        check("rst.busy", {busy0, busy1}, 2'b00);
        check("rst.valid", {nv0, nv1}, 2'b00);
        step();
        check("lfsr.adv", lfsr0, 16'hE270);

        // Seed 0001 gives sampled states 0001, B400, 5A00, 2D00.
        do_reset(2);
        fetch_check("seed0001", 16'h0001, 4, 16'h0000, 4, 16'h0001);
        // Seed 1234 gives sampled states 1234, 091A, 048D, B646, 5B23, 9991.
        // Rejection skips the nibbles A and D, so u_dut1 runs for 6 cycles.
        do_reset(2);
        fetch_check("seed1234", 16'h1234, 4, 16'h3862, 6, 16'h1364);

        // With fetch_req held high, u_dut0 returns a number every N+2 cycles.
        do_reset(2);
        fetch_req = 1'b1;
        np = 0; last = 0; bad = 0; first = 0;
        for (int c = 1; c <= 62; c++) begin
            step();
            if (nv0) begin
                np++;
                if (first == 0) first = c;
                if (last != 0 && (c - last) != 6) bad++;
                last = c;
            end
        end
        fetch_req = 1'b0;
        check("cont.first", first, 6);
        check("cont.pulses", np, 10);
        check("cont.period", bad, 0);

        // fetch_req pulses while busy or in DONE are ignored.
        do_reset(2);
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        np = (nv0) ? 1 : 0;
        for (int c = 2; c <= 20; c++) begin
            fetch_req = (c == 3 || c == 5 || c == 6);
            step();
            if (nv0) np++;
        end
        fetch_req = 1'b0;
        check("ignore.pulses", np, 1);
        check("ignore.busy", busy0, 1'b0);

        // A zero seed is replaced by SEED, and the LFSR period is 2^16-1.
        do_reset(2);
        repeat (5) step();
        seed_in = 16'h0000; seed_load = 1'b1;
        step();
        seed_load = 1'b0;
        check("zseed.lfsr0", lfsr0, 16'hACE1);
        check("zseed.lfsr1", lfsr1, 16'hACE1);
        z = 0; ret = 0;
        for (int i = 1; i <= 65535; i++) begin
            step();
            if (lfsr0 == 16'h0000) z++;
            if (lfsr0 == 16'hACE1 && ret == 0) ret = i;
        end
        check("period.zero", z, 0);
        check("period.len", ret, 65535);

        // A reset during the second GEN cycle aborts the fetch, so no pulse follows.
        do_reset(2);
        seed_in = 16'h1234; seed_load = 1'b1; fetch_req = 1'b1;
        step();
        seed_load = 1'b0; fetch_req = 1'b0;
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("abort.busy", {busy0, busy1}, 2'b00);
        check("abort.lfsr", lfsr0, 16'hACE1);
        np = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (nv0 || nv1) np++;
        end
        check("abort.pulses", np, 0);
        check("abort.digits0", digits0, 16'h0000);
        check("abort.digits1", digits1, 16'h0000);

        // This is a long run with rejection sampling. Consecutive LFSR nibbles
        // share 3 bits, so the histogram is not flat. The bench therefore
        // requires only that every digit is BCD and that every value 0..9
        // occurs at least once.
        do_reset(2);
        for (int k = 0; k < 10; k++) hist[k] = 0;
        fetch_req = 1'b1;
        n1 = 0; bad = 0; cyc = 0;
        while (n1 < 1500 && cyc < 30000) begin
            step();
            cyc++;
            if (nv1) begin
                n1++;
                for (int k = 0; k < 4; k++) begin
                    if (digits1[4*k +: 4] > 4'd9) bad++;
                    else hist[digits1[4*k +: 4]]++;
                end
            end
            if (nv0) begin
                for (int k = 0; k < 4; k++)
                    if (digits0[4*k +: 4] > 4'd9) bad++;
            end
        end
        fetch_req = 1'b0;
        check("dist.fetches", n1, 1500);
        check("dist.bcd", bad, 0);
        for (int k = 0; k < 10; k++)
            check($sformatf("dist.hist%0d", k), (hist[k] > 0), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
